cdb_writeback_arbiter: RTL and testbench

Arbitrates among the functional-unit result producers (ALU, MUL/DIV, LOAD) for the single common data bus (CDB) and the register file's single write port. Each cycle it grants one valid requester and registers the winning result. On the next cycle it broadcasts the result as tag and data to the reservation stations, and drives `RegWrite`/`writeaddr`/`writedata` into the register file. The register file commits on the falling edge of that same cycle.

---
 rtl/cdb_writeback_arbiter.sv | 102 ++++++++++
 tb/tb_cdb_writeback_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cdb_writeback_arbiter.sv
// Common-data-bus / register-file write-port arbiter: grants one result producer per cycle
// and registers the winner for broadcast. Define CDB_RR_EN for round-robin, else fixed priority.
module cdb_writeback_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int TAG_W   = 4,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    input  logic [NUM_REQ*ADDR_W-1:0] req_rd,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      flush,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_data,
    output logic                      RegWrite,
    output logic [ADDR_W-1:0]         writeaddr,
    output logic [DATA_W-1:0]         writedata
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic              transfer;
    logic [TAG_W-1:0]  sel_tag;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;
    int                idx;

`ifdef CDB_RR_EN
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] gnt_idx;
`endif

    // NOTE: every combinational output gets a default before the search loop, so no latch can form.
    always_comb begin
        req_ready = '0;
        transfer  = 1'b0;
        sel_tag   = '0;
        sel_rd    = '0;
        sel_data  = '0;
        idx       = 0;
`ifdef CDB_RR_EN
        gnt_idx   = '0;
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef CDB_RR_EN
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
`else
            idx = k;
`endif
            // Grants are suppressed during reset and flush; first valid index in search order wins.
            if (!transfer && req_valid[idx] && !flush && !rst) begin
                transfer       = 1'b1;
                req_ready[idx] = 1'b1;
                sel_tag        = req_tag[idx*TAG_W +: TAG_W];
                sel_rd         = req_rd[idx*ADDR_W +: ADDR_W];
                sel_data       = req_data[idx*DATA_W +: DATA_W];
`ifdef CDB_RR_EN
                gnt_idx        = IDX_W'(idx);
`endif
            end
        end
    end

`ifdef CDB_RR_EN
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (transfer) begin
            rr_ptr <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
        end
    end
`endif

    // Tag, address and data hold when idle; only the valid/enable strobes drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            RegWrite  <= 1'b0;
            writeaddr <= '0;
            writedata <= '0;
        end else begin
            cdb_valid <= transfer;
            RegWrite  <= transfer && (sel_rd != '0);
            if (transfer) begin
                cdb_tag   <= sel_tag;
                cdb_data  <= sel_data;
                writeaddr <= sel_rd;
                writedata <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// Directed bench for cdb_writeback_arbiter with a falling-edge register-file model;
// expectations follow CDB_RR_EN the same way the design does.
module tb_cdb_writeback_arbiter;

    localparam int NUM_REQ = 3;
    localparam int TAG_W   = 4;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*TAG_W-1:0]  req_tag;
    logic [NUM_REQ*ADDR_W-1:0] req_rd;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic                      flush;
    logic                      cdb_valid;
    logic [TAG_W-1:0]          cdb_tag;
    logic [DATA_W-1:0]         cdb_data;
    logic                      RegWrite;
    logic [ADDR_W-1:0]         writeaddr;
    logic [DATA_W-1:0]         writedata;

    logic [DATA_W-1:0] rf [32];

    int n_cmp = 0;
    int n_err = 0;

    cdb_writeback_arbiter #(
        .NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_tag(req_tag), .req_rd(req_rd), .req_data(req_data),
        .flush(flush),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .RegWrite(RegWrite), .writeaddr(writeaddr), .writedata(writedata)
    );

    always #5 clk = ~clk;

    // Register file commits on the falling edge inside the broadcast cycle; x0 is hardwired.
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) rf[r] <= '0;
        end else if (RegWrite && writeaddr != '0) begin
            rf[writeaddr] <= writedata;
        end
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic set_req(input int i, input logic [TAG_W-1:0] t, input logic [ADDR_W-1:0] rd,
                           input logic [DATA_W-1:0] d);
        req_tag[i*TAG_W +: TAG_W]    = t;
        req_rd[i*ADDR_W +: ADDR_W]   = rd;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [NUM_REQ-1:0] exp_ready;
    logic [TAG_W-1:0]   exp_tag;

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        req_valid = 3'b111;
        req_tag   = '0;
        req_rd    = '0;
        req_data  = '0;
        set_req(0, 4'h1, 5'd1, 32'hA0A0_0000);
        set_req(1, 4'h2, 5'd2, 32'hB0B0_0001);
        set_req(2, 4'h3, 5'd3, 32'hC0C0_0002);

        // Reset held with every producer requesting.
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 64'(req_ready), 64'(3'b000));
        check("rst_cdb_valid", 64'(cdb_valid), 64'd0);
        check("rst_regwrite", 64'(RegWrite), 64'd0);
        check("rst_tag_addr", {32'(cdb_tag), 32'(writeaddr)}, 64'd0);
        check("rst_data", {cdb_data, writedata}, 64'd0);

        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 64'(req_ready), 64'(3'b001));
        tick();
        check("first_cdb_valid", 64'(cdb_valid), 64'd1);
        check("first_tag", 64'(cdb_tag), 64'h1);
        check("first_regwrite", 64'(RegWrite), 64'd1);
        check("first_wb", {32'(writeaddr), writedata}, {32'd1, 32'hA0A0_0000});

        // Idle cycle: strobes drop, payload holds.
        req_valid = 3'b000;
        #1;
        check("idle_ready", 64'(req_ready), 64'd0);
        tick();
        check("idle_cdb_valid", 64'(cdb_valid), 64'd0);
        check("idle_regwrite", 64'(RegWrite), 64'd0);
        check("idle_tag_hold", 64'(cdb_tag), 64'h1);

        // Single request from producer 1.
        set_req(1, 4'h5, 5'd7, 32'hDEAD_BEEF);
        req_valid = 3'b010;
        #1;
        check("single_ready", 64'(req_ready), 64'(3'b010));
        tick();
        req_valid = 3'b000;
        check("single_cdb_valid", 64'(cdb_valid), 64'd1);
        check("single_tag", 64'(cdb_tag), 64'h5);
        check("single_regwrite", 64'(RegWrite), 64'd1);
        check("single_wb", {32'(writeaddr), writedata}, {32'd7, 32'hDEAD_BEEF});
        @(negedge clk);
        #1;
        check("single_rf_x7", 64'(rf[7]), 64'hDEAD_BEEF);

        // rd = 0 from producer 2: broadcast without register write.
        set_req(2, 4'hA, 5'd0, 32'h0000_1234);
        @(posedge clk);
        #1;
        req_valid = 3'b100;
        #1;
        check("rd0_ready", 64'(req_ready), 64'(3'b100));
        tick();
        req_valid = 3'b000;
        check("rd0_cdb_valid", 64'(cdb_valid), 64'd1);
        check("rd0_tag", 64'(cdb_tag), 64'hA);
        check("rd0_data", 64'(cdb_data), 64'h1234);
        check("rd0_regwrite", 64'(RegWrite), 64'd0);
        @(negedge clk);
        #1;
        check("rd0_rf_x0", 64'(rf[0]), 64'd0);

        // All three valid for six back-to-back cycles.
        set_req(1, 4'h2, 5'd2, 32'hB0B0_0001);
        set_req(2, 4'h3, 5'd3, 32'hC0C0_0002);
        @(posedge clk);
        #1;
        req_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
`ifdef CDB_RR_EN
            exp_ready = 3'b001 << (c % 3);
            exp_tag   = 4'(c % 3 + 1);
`else
            exp_ready = 3'b001;
            exp_tag   = 4'h1;
`endif
            #1;
            check($sformatf("all_ready_%0d", c), 64'(req_ready), 64'(exp_ready));
            tick();
            check($sformatf("all_valid_%0d", c), 64'(cdb_valid), 64'd1);
            check($sformatf("all_tag_%0d", c), 64'(cdb_tag), 64'(exp_tag));
        end

        // One more grant (index 0 in both builds), then flush with everyone requesting.
        tick();
        flush = 1'b1;
        #1;
        check("flush_ready", 64'(req_ready), 64'd0);
        check("flush_out_visible", 64'(cdb_valid), 64'd1);
        tick();
        flush = 1'b0;
        check("flush_cdb_valid", 64'(cdb_valid), 64'd0);
        check("flush_regwrite", 64'(RegWrite), 64'd0);
`ifdef CDB_RR_EN
        exp_ready = 3'b010;
`else
        exp_ready = 3'b001;
`endif
        #1;
        check("post_flush_ready", 64'(req_ready), 64'(exp_ready));

        // Producers 1 and 2 only, three cycles.
        req_valid = 3'b110;
        for (int c = 0; c < 3; c++) begin
`ifdef CDB_RR_EN
            exp_ready = (c == 1) ? 3'b100 : 3'b010;
`else
            exp_ready = 3'b010;
`endif
            exp_tag = (exp_ready == 3'b100) ? 4'h3 : 4'h2;
            #1;
            check($sformatf("hi_ready_%0d", c), 64'(req_ready), 64'(exp_ready));
            tick();
            check($sformatf("hi_tag_%0d", c), 64'(cdb_tag), 64'(exp_tag));
        end

        // Asynchronous reset while a result is being broadcast.
        check("pre_async_valid", 64'(cdb_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_cdb_valid", 64'(cdb_valid), 64'd0);
        check("async_tag_addr", {32'(cdb_tag), 32'(writeaddr)}, 64'd0);
        check("async_regwrite", 64'(RegWrite), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
